// File: rtl/chan_merge_buf.sv
// Multi-channel merge buffer: per-channel FIFOs feeding a round-robin
// arbiter and a single registered output stage.
module chan_merge_buf #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        fifo_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
    logic [AW:0]       wptr [NUM_CH];
    logic [AW:0]       rptr [NUM_CH];

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] wr_en;
    logic              ready_en;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant;
    logic              grant_found;
    logic              load;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][AW] != rptr[i][AW]) &&
                       (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
        end
    end

    // ready_en keeps in_ready low for the first cycle after reset, purely from flops
    assign in_ready   = ready_en ? ~full : '0;
    assign wr_en      = in_valid & in_ready;
    assign fifo_empty = empty;
    assign eligible   = ~empty & ch_enable;

    always_comb begin
        logic [CH_W-1:0] cand;
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((32'(last_grant) + 32'd1 + k) % NUM_CH);
            if (!grant_found && eligible[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign load = (!out_valid || out_ready) && grant_found;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_en[i]) begin
                mem[i][wptr[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_en[i]) begin
                    wptr[i] <= wptr[i] + (AW+1)'(1);
                end
            end
            if (load) begin
                out_valid     <= 1'b1;
                out_data      <= mem[grant][rptr[grant][AW-1:0]];
                out_ch        <= grant;
                last_grant    <= grant;
                rptr[grant]   <= rptr[grant] + (AW+1)'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
